// File: rtl/echo_request_deserializer.sv
// Parses header+payload frames from the host word stream and issues request_say(meth, v).
// Define ECHO_DESER_ERRCNT_EN to add the saturating err_count output for dropped frames.
module echo_request_deserializer #(
   parameter int          ERR_W         = 8,
   parameter logic [15:0] SAY_METHOD_ID = 16'h0000,
   parameter logic [15:0] SAY_LEN       = 16'd2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_word__ENA,
   input  logic [31:0]       in_word_data,
   output logic              in_word__RDY,
   output logic              request_say__ENA,
   output logic [31:0]       request_say_meth,
   output logic [31:0]       request_say_v,
`ifdef ECHO_DESER_ERRCNT_EN
   output logic [ERR_W-1:0]  err_count,
`endif
   input  logic              request_say__RDY
);

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      PAY0  = 3'd1,
      PAY1  = 3'd2,
      DRAIN = 3'd3,
      ISSUE = 3'd4
   } stateT;

   stateT       state_q, state_d;
   logic [31:0] meth_q, meth_d;
   logic [31:0] v_q, v_d;
   logic [15:0] drain_q, drain_d;
   logic        badFrame;
   logic        wordAccept;
   logic        sayFire;
   logic [15:0] hdrId;
   logic [15:0] hdrLen;

   assign hdrId      = in_word_data[31:16];
   assign hdrLen     = in_word_data[15:0];
   assign wordAccept = in_word__ENA && in_word__RDY;
   assign sayFire    = (state_q == ISSUE) && request_say__RDY;

   assign in_word__RDY     = (state_q != ISSUE);
   assign request_say__ENA = sayFire;
   assign request_say_meth = meth_q;
   assign request_say_v    = v_q;

   // Next-state logic for the frame parser: header decode, payload capture, drain and issue.
   // A zero-length bad frame has nothing to drain, so it is dropped without leaving HDR.
   always_comb begin
      state_d  = state_q;
      meth_d   = meth_q;
      v_d      = v_q;
      drain_d  = drain_q;
      badFrame = 1'b0;
      case (state_q)
         HDR: begin
            if (wordAccept) begin
               if (hdrId == SAY_METHOD_ID && hdrLen == SAY_LEN) begin
                  state_d = PAY0;
               end else begin
                  badFrame = 1'b1;
                  if (hdrLen != 16'd0) begin
                     drain_d = hdrLen;
                     state_d = DRAIN;
                  end
               end
            end
         end
         PAY0: begin
            if (wordAccept) begin
               meth_d  = in_word_data;
               state_d = PAY1;
            end
         end
         PAY1: begin
            if (wordAccept) begin
               v_d     = in_word_data;
               state_d = ISSUE;
            end
         end
         DRAIN: begin
            if (wordAccept) begin
               drain_d = drain_q - 16'd1;
               if (drain_q == 16'd1) begin
                  state_d = HDR;
               end
            end
         end
         ISSUE: begin
            if (sayFire) begin
               state_d = HDR;
            end
         end
         default: begin
            state_d = HDR;
         end
      endcase
   end

`ifdef ECHO_DESER_ERRCNT_EN
   logic [ERR_W-1:0] err_q, err_d;

   // Saturate at all-ones so a burst of garbage cannot wrap the count back to small values.
   always_comb begin
      err_d = err_q;
      if (badFrame && (err_q != {ERR_W{1'b1}})) begin
         err_d = err_q + 1'b1;
      end
   end

   // Error counter register, cleared by the synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_count = err_q;
`endif

   // Parser state and argument registers; reset discards any partial frame.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= HDR;
         meth_q  <= 32'd0;
         v_q     <= 32'd0;
         drain_q <= 16'd0;
      end else begin
         state_q <= state_d;
         meth_q  <= meth_d;
         v_q     <= v_d;
         drain_q <= drain_d;
      end
   end

endmodule

// File: tb/tb_echo_request_deserializer.sv
// Directed self-checking bench for echo_request_deserializer; err_count checks only when
// ECHO_DESER_ERRCNT_EN is defined (counter built with ERR_W=2 to reach saturation).
module tb_echo_request_deserializer;

   logic        CLK;
   logic        nRST;
   logic        inWordEna;
   logic [31:0] inWordData;
   logic        inWordRdy;
   logic        sayEna;
   logic [31:0] sayMeth;
   logic [31:0] sayV;
   logic        sayRdy;
`ifdef ECHO_DESER_ERRCNT_EN
   logic [1:0]  errCount;
`endif

   int vectors;
   int miscompares;

   echo_request_deserializer #(.ERR_W(2)) dut (
      .CLK              (CLK),
      .nRST             (nRST),
      .in_word__ENA     (inWordEna),
      .in_word_data     (inWordData),
      .in_word__RDY     (inWordRdy),
      .request_say__ENA (sayEna),
      .request_say_meth (sayMeth),
      .request_say_v    (sayV),
`ifdef ECHO_DESER_ERRCNT_EN
      .err_count        (errCount),
`endif
      .request_say__RDY (sayRdy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic applyStimulus(input logic ena, input logic [31:0] data, input logic coreRdy);
      @(negedge CLK);
      inWordEna  = ena;
      inWordData = data;
      sayRdy     = coreRdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkErr(input string tag, input logic [31:0] expected);
`ifdef ECHO_DESER_ERRCNT_EN
      checkOutput(tag, {30'd0, errCount}, expected);
`else
      if (expected == 32'hFFFF_FFFF) $display("[TB] unreachable %s", tag);
`endif
   endtask

   // Directed test sequence following the specification's TESTING list.
   initial begin
      vectors     = 0;
      miscompares = 0;
      nRST        = 1'b0;
      inWordEna   = 1'b0;
      inWordData  = 32'd0;
      sayRdy      = 1'b1;

      repeat (2) @(posedge CLK);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("rst_rdy", {31'd0, inWordRdy}, 32'd1);
      checkOutput("rst_ena", {31'd0, sayEna}, 32'd0);
      checkOutput("rst_meth", sayMeth, 32'd0);
      checkOutput("rst_v", sayV, 32'd0);
      checkErr("rst_err", 32'd0);
      nRST = 1'b1;

      applyStimulus(1'b1, 32'h0000_0002, 1'b1);
      checkOutput("t1_hdr_rdy", {31'd0, inWordRdy}, 32'd1);
      applyStimulus(1'b1, 32'h0000_0011, 1'b1);
      checkOutput("t1_p0_ena", {31'd0, sayEna}, 32'd0);
      applyStimulus(1'b1, 32'h0000_0022, 1'b1);
      checkOutput("t1_p1_ena", {31'd0, sayEna}, 32'd0);
      checkOutput("t1_p1_meth", sayMeth, 32'h11);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t1_iss_ena", {31'd0, sayEna}, 32'd1);
      checkOutput("t1_iss_rdy", {31'd0, inWordRdy}, 32'd0);
      checkOutput("t1_iss_meth", sayMeth, 32'h11);
      checkOutput("t1_iss_v", sayV, 32'h22);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t1_post_ena", {31'd0, sayEna}, 32'd0);
      checkOutput("t1_post_rdy", {31'd0, inWordRdy}, 32'd1);
      checkOutput("t1_hold_v", sayV, 32'h22);

      applyStimulus(1'b1, 32'h0000_0002, 1'b0);
      applyStimulus(1'b1, 32'h0000_00AA, 1'b0);
      applyStimulus(1'b1, 32'h0000_00BB, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'd0, 1'b0);
         checkOutput("t2_stall_ena", {31'd0, sayEna}, 32'd0);
         checkOutput("t2_stall_rdy", {31'd0, inWordRdy}, 32'd0);
         checkOutput("t2_stall_meth", sayMeth, 32'hAA);
         checkOutput("t2_stall_v", sayV, 32'hBB);
      end
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t2_fire_ena", {31'd0, sayEna}, 32'd1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t2_post_rdy", {31'd0, inWordRdy}, 32'd1);
      checkOutput("t2_post_ena", {31'd0, sayEna}, 32'd0);

      applyStimulus(1'b1, 32'h0007_0003, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b1, i, 1'b1);
         checkOutput("t3_drain_ena", {31'd0, sayEna}, 32'd0);
         checkOutput("t3_drain_rdy", {31'd0, inWordRdy}, 32'd1);
      end
      applyStimulus(1'b1, 32'h0000_0002, 1'b1);
      applyStimulus(1'b1, 32'h0000_0055, 1'b1);
      applyStimulus(1'b1, 32'h0000_0066, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t3_iss_ena", {31'd0, sayEna}, 32'd1);
      checkOutput("t3_iss_meth", sayMeth, 32'h55);
      checkOutput("t3_iss_v", sayV, 32'h66);
      checkErr("t3_err", 32'd1);

      applyStimulus(1'b1, 32'h0000_0001, 1'b1);
      applyStimulus(1'b1, 32'h0000_0099, 1'b1);
      applyStimulus(1'b1, 32'h0005_0000, 1'b1);
      checkErr("t4_err_len", 32'd2);
      applyStimulus(1'b1, 32'h0000_0002, 1'b1);
      checkErr("t4_err_zero", 32'd3);
      applyStimulus(1'b1, 32'h0000_0077, 1'b1);
      applyStimulus(1'b1, 32'h0000_0088, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t4_iss_ena", {31'd0, sayEna}, 32'd1);
      checkOutput("t4_iss_meth", sayMeth, 32'h77);
      checkOutput("t4_iss_v", sayV, 32'h88);

      applyStimulus(1'b1, 32'h0000_0002, 1'b1);
      applyStimulus(1'b1, 32'h0000_0012, 1'b1);
      @(negedge CLK);
      inWordEna = 1'b0;
      nRST      = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t5_rst_rdy", {31'd0, inWordRdy}, 32'd1);
      checkOutput("t5_rst_ena", {31'd0, sayEna}, 32'd0);
      checkOutput("t5_rst_meth", sayMeth, 32'd0);
      checkOutput("t5_rst_v", sayV, 32'd0);
      checkErr("t5_rst_err", 32'd0);
      nRST = 1'b1;
      applyStimulus(1'b1, 32'h0000_0002, 1'b1);
      applyStimulus(1'b1, 32'h0000_0033, 1'b1);
      applyStimulus(1'b1, 32'h0000_0044, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t5_iss_ena", {31'd0, sayEna}, 32'd1);
      checkOutput("t5_iss_meth", sayMeth, 32'h33);
      checkOutput("t5_iss_v", sayV, 32'h44);
      checkErr("t5_err", 32'd0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h0005_0000, 1'b1);
      end
      applyStimulus(1'b1, 32'h0000_0002, 1'b1);
      checkErr("t6_err_sat", 32'd3);
      applyStimulus(1'b1, 32'h0000_00C1, 1'b1);
      applyStimulus(1'b1, 32'h0000_00C2, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t6_iss_ena", {31'd0, sayEna}, 32'd1);
      checkOutput("t6_iss_v", sayV, 32'hC2);

      applyStimulus(1'b1, 32'h0001_FFFF, 1'b1);
      for (int i = 0; i < 65535; i++) begin
         @(negedge CLK);
         inWordEna  = 1'b1;
         inWordData = 32'h0000_0002;
      end
      #1;
      checkOutput("max_last_ena", {31'd0, sayEna}, 32'd0);
      applyStimulus(1'b1, 32'h0000_0002, 1'b1);
      applyStimulus(1'b1, 32'h0000_00D1, 1'b1);
      applyStimulus(1'b1, 32'h0000_00D2, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("max_iss_ena", {31'd0, sayEna}, 32'd1);
      checkOutput("max_iss_meth", sayMeth, 32'hD1);
      checkOutput("max_iss_v", sayV, 32'hD2);
      checkErr("max_err", 32'd3);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
